// File: rtl/lc3b_types.sv
// Shared LC-3b types: instruction opcodes, machine word, and MEM-stage state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef enum logic [1:0] {
    IDLE,
    ACC1,
    ACC2,
    DONE
  } mem_state_t;

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering for LDB/STB: replicated store byte, lane mask, zero-extended load byte.
module mem_byte_align
  import lc3b_types::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              lane,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] store_data,
  output logic [1:0]        byte_enable,
  output logic [DATA_W-1:0] load_data
);

  logic is_stb;
  logic is_ldb;

  always_comb begin
    is_stb = (opcode == op_stb);
    is_ldb = (opcode == op_ldb);

    store_data  = wdata;
    byte_enable = 2'b11;
    load_data   = rdata;

    if (is_stb) begin
      store_data  = DATA_W'({wdata[7:0], wdata[7:0]});
      byte_enable = lane ? 2'b10 : 2'b01;
    end
    if (is_ldb) begin
      load_data = DATA_W'(lane ? rdata[15:8] : rdata[7:0]);
    end
  end

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage data-port engine: single and two-access (LDI/STI) transactions with pipeline stall.
module mem_stage_access
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ctrl_valid,
  input  logic [3:0]        opcode,
  input  logic              mem2_read,
  input  logic              mem2_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  input  logic              dmem_resp,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [1:0]        dmem_byte_enable,
  output logic              stall,
  output logic [DATA_W-1:0] mdr_out,
  output logic              done
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [3:0]        opcode_q, opcode_d;
  logic              lane_q, lane_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              ind_q, ind_d;

  logic              rd_req, wr_req, indirect, req, is_sti;
  logic [DATA_W-1:0] al_store, al_load;
  logic [1:0]        al_be;

  mem_byte_align #(.DATA_W(DATA_W)) u_align (
    .lane        (lane_q),
    .opcode      (opcode_q),
    .rdata       (dmem_rdata),
    .wdata       (wdata_q),
    .store_data  (al_store),
    .byte_enable (al_be),
    .load_data   (al_load)
  );

  always_comb begin
    rd_req   = mem2_read | (opcode == op_ldb) | (opcode == op_trap);
    wr_req   = mem2_write;
    indirect = (opcode == op_ldi) | (opcode == op_sti);
    req      = ctrl_valid & (rd_req | wr_req);
    is_sti   = (opcode_q == op_sti);

    state_d  = state_q;
    addr_d   = addr_q;
    ptr_d    = ptr_q;
    wdata_d  = wdata_q;
    mdr_d    = mdr_q;
    opcode_d = opcode_q;
    lane_d   = lane_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    ind_d    = ind_q;

    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = '0;
    dmem_wdata       = '0;
    dmem_byte_enable = 2'b11;
    stall            = 1'b0;
    done             = 1'b0;

    unique case (state_q)
      IDLE: begin
        stall = req;
        if (req) begin
          addr_d   = address;
          wdata_d  = wdata;
          opcode_d = opcode;
          lane_d   = address[0];
          rd_d     = rd_req;
          wr_d     = wr_req;
          ind_d    = indirect;
          state_d  = ACC1;
        end
      end
      ACC1: begin
        // Indirect ops always fetch the pointer first, even STI.
        dmem_address     = addr_q;
        dmem_read        = rd_q | ind_q;
        dmem_write       = wr_q & ~ind_q;
        dmem_wdata       = al_store;
        dmem_byte_enable = al_be;
        stall            = 1'b1;
        if (dmem_resp) begin
          if (ind_q) begin
            ptr_d   = ADDR_W'(dmem_rdata);
            state_d = ACC2;
          end else begin
            if (rd_q) mdr_d = al_load;
            state_d = DONE;
          end
        end
      end
      ACC2: begin
        dmem_address = ptr_q;
        dmem_read    = ~is_sti;
        dmem_write   = is_sti;
        dmem_wdata   = is_sti ? wdata_q : '0;
        stall        = 1'b1;
        if (dmem_resp) begin
          if (!is_sti) mdr_d = dmem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      ptr_q    <= '0;
      wdata_q  <= '0;
      mdr_q    <= '0;
      opcode_q <= '0;
      lane_q   <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ind_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ptr_q    <= ptr_d;
      wdata_q  <= wdata_d;
      mdr_q    <= mdr_d;
      opcode_q <= opcode_d;
      lane_q   <= lane_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ind_q    <= ind_d;
    end
  end

  assign mdr_out = mdr_q;

endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- MEM-stage engine that consumes the decoded control word and carries out the data-memory traffic it requests.
- Drives the data-port handshake (read/write/resp) and sequences two-access LDI/STI and TRAP vector fetches.
- Applies byte-lane alignment for LDB/STB.
- Holds the pipeline stalled until the access completes, then hands the loaded word to the MEM/WB register.

Parameters:
- ADDR_W, 16, data-memory address width
- DATA_W, 16, data word width

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ctrl_valid  in  1  EX/MEM holds a valid (non-NOP) instruction
- opcode  in  4  lc3b_opcode of EX/MEM instruction
- mem2_read  in  1  control-word read request
- mem2_write  in  1  control-word write request
- address  in  ADDR_W  effective address from EX (ALU/adder result)
- wdata  in  DATA_W  store source register value
- dmem_resp  in  1  memory completion strobe
- dmem_rdata  in  DATA_W  memory read data
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_address  out  ADDR_W  access address
- dmem_wdata  out  DATA_W  write data
- dmem_byte_enable  out  2  write lane mask
- stall  out  1  freeze PC/IF-ID/ID-EX/EX-MEM loads
- mdr_out  out  DATA_W  loaded data for MEM/WB
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, reset_n=0): state=IDLE; dmem_read=dmem_write=0; dmem_address=0; dmem_wdata=0; dmem_byte_enable=2'b11; mdr_out=0; done=0; internal pointer/operands cleared. Reset mid-access abandons the transaction; the memory model must tolerate a dropped request.
- Request classification, evaluated in IDLE only:
  - rd_req = mem2_read | opcode==LDB | opcode==TRAP
  - wr_req = mem2_write
  - indirect = opcode==LDI | opcode==STI
  - req = ctrl_valid & (rd_req | wr_req)
- IDLE:
  - stall = req (combinational, same cycle).
  - On req: register address, wdata, opcode and the lane select addr[0], then go to ACC1.
  - With no req, stall=0 and done=0.
- ACC1:
  - dmem_address = the registered address.
  - dmem_read = rd_req | indirect; dmem_write = wr_req & ~indirect. STI's first access is always a read.
  - stall=1. The request is held stable until dmem_resp; resp outside ACC1/ACC2 is ignored.
  - On resp with indirect: latch dmem_rdata as the pointer, go to ACC2.
  - On resp otherwise: latch the aligned read data into mdr_out, go to DONE.
- ACC2:
  - dmem_address = pointer. LDI: dmem_read=1. STI: dmem_write=1, dmem_wdata=the registered wdata, byte_enable=2'b11.
  - stall=1. On resp: LDI latches dmem_rdata into mdr_out. Go to DONE.
- DONE:
  - stall=0, done=1, mdr_out stable. The pipeline advances at the end of this cycle.
  - Inputs are ignored (they still show the finished instruction). Next state is IDLE unconditionally.
- Byte rules:
  - STB: dmem_wdata = {wdata[7:0], wdata[7:0]}; byte_enable = addr[0] ? 2'b10 : 2'b01.
  - LDB: mdr_out = zero-extended dmem_rdata[15:8] if addr[0] else [7:0].
  - Word accesses use addr unchanged and byte_enable 2'b11.
- Latency: a single access takes (entry cycle) + (wait cycles through resp) + DONE. With resp in the first ACC1 cycle, a stall-free load completes in 3 cycles, with stall high for 2.
- Back-to-back memory instructions: the second is seen in IDLE on the cycle after DONE; there is no dead cycle beyond IDLE.

Decomposition:
- lc3b_types gains mem_state_t (IDLE, ACC1, ACC2, DONE).
- Existing lc3b_opcode/lc3b_word are reused from lc3b_types; no new constants beyond the enum.
- One combinational sub-module, mem_byte_align: takes addr[0], opcode and rdata/wdata; produces the aligned store data, byte_enable and the zext load byte.
- The FSM stays in mem_stage_access.

Test Plan:
- LDR, addr=0x1000, rdata=0xBEEF, resp after 2 wait cycles -> dmem_read high 3 cycles at 0x1000; stall high until DONE; done pulses once; mdr_out=0xBEEF.
- STB, addr=0x2003, wdata=0x12A5 -> dmem_write=1, dmem_wdata=0xA5A5, byte_enable=2'b10; mdr_out unchanged; done pulse.
- LDI, addr=0x3000, first rdata=0x4000, second rdata=0x0042 -> read 0x3000, then read 0x4000; mdr_out=0x0042; exactly two dmem_resp consumed.
- STI, addr=0x3000, pointer=0x5000, wdata=0x7777 -> read 0x3000, then write 0x7777 to 0x5000 with byte_enable=2'b11; no write at 0x3000.
- LDB at 0x0601 with rdata=0x9C11 -> mdr_out=0x009C. ADD with ctrl_valid=1 -> stall=0, no dmem activity.
- reset_n pulsed low in ACC2 of LDI -> dmem_read/write drop immediately, state IDLE, done never pulses. Spurious dmem_resp in IDLE is ignored.
